xfir_coef_loader: RTL and testbench

//  Writable coefficient store for the polyphase FIR; the write-side counterpart of the coefficient ROMs.

---
 rtl/xfir_coef_loader.sv | 106 ++++++++++
 tb/tb_xfir_coef_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/xfir_coef_loader.sv
// Writable coefficient store for the polyphase FIR: valid/ready write stream into block RAM, ROM-timed read port.
// Define XFIR_COEF_BANKSWAP_EN for a double-depth RAM with shadow-bank loading and swap on completion.
module xfir_coef_loader #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 18
) (
  input  logic          clka,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic [AW:0]   load_count,
  input  logic          load_abort,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          busy,
  output logic          done,
  output logic          start_err,
  input  logic [AW-1:0] addra,
  output logic [DW-1:0] douta
);

`ifdef XFIR_COEF_BANKSWAP_EN
  localparam int unsigned RAW = AW + 1;
`else
  localparam int unsigned RAW = AW;
`endif
  localparam logic [AW:0] MAX_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   waddr;
  logic [AW:0]     remaining;
  logic            beat;
  logic [RAW-1:0]  wa, ra;
  logic [DW-1:0]   ram [0:(1 << RAW) - 1];

  // Abort wins over a beat presented on the same edge.
  assign beat = (state == LOAD) && s_valid && !load_abort;

`ifdef XFIR_COEF_BANKSWAP_EN
  logic bank;
  assign wa = {~bank, waddr};
  assign ra = {bank, addra};

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)              bank <= 1'b0;
    else if (state == DONE)  bank <= ~bank;
  end
`else
  assign wa = waddr;
  assign ra = addra;
`endif

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load_start) state_nx = (load_count == '0) ? DONE : LOAD;
      LOAD: begin
        if (load_abort)                    state_nx = IDLE;
        else if (beat && remaining == ONE) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      waddr     <= '0;
      remaining <= '0;
    end else if (state == IDLE && load_start) begin
      waddr     <= '0;
      remaining <= (load_count > MAX_CNT) ? MAX_CNT : load_count;
    end else if (beat) begin
      waddr     <= waddr + 1'b1;
      remaining <= remaining - ONE;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)          start_err <= 1'b0;
    else if (load_start) start_err <= (state != IDLE);
  end

  always_ff @(posedge clka) begin
    if (beat) ram[wa] <= s_data;
  end

  // Separate nonblocking read gives read-first behaviour on a same-address collision.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) douta <= '0;
    else        douta <= ram[ra];
  end

  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_xfir_coef_loader.sv
// Self-checking bench for xfir_coef_loader: randomized loads checked against an array model of the coefficient store.
// Honours XFIR_COEF_BANKSWAP_EN the same way as the design.
module tb_xfir_coef_loader;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int DEPTH = 1 << AW;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_count = '0;
  logic          load_abort = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, busy, done, start_err;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] douta;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [0:2*DEPTH-1];
  bit            known [0:2*DEPTH-1];
  bit            bank_m = 1'b0;

  xfir_coef_loader #(.AW(AW), .DW(DW)) dut (
    .clka(clka), .rst_n(rst_n), .load_start(load_start), .load_count(load_count),
    .load_abort(load_abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .start_err(start_err), .addra(addra), .douta(douta)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: loads fill the shadow half, reads come from the active half; one half when swapping is off.
  function automatic int wbase();
`ifdef XFIR_COEF_BANKSWAP_EN
    return bank_m ? 0 : DEPTH;
`else
    return 0;
`endif
  endfunction

  function automatic int rbase();
`ifdef XFIR_COEF_BANKSWAP_EN
    return bank_m ? DEPTH : 0;
`else
    return 0;
`endif
  endfunction

  task automatic load_finished();
`ifdef XFIR_COEF_BANKSWAP_EN
    bank_m = ~bank_m;
`endif
  endtask

  task automatic read_check(input int a);
    if (known[rbase() + a]) begin
      addra = a[AW-1:0];
      @(negedge clka);
      chk("douta", douta, mem_m[rbase() + a]);
    end
  endtask

  // mode: 0 = s_valid held high, 1 = toggling (low first), 2 = random.
  task automatic run_load(input int count, input int mode, input int abort_at,
                          input int dup_at, output int cycles);
    int  n, acc;
    bit  v;
    n = (count > DEPTH) ? DEPTH : count;
    cycles = 0;
    load_count = count[AW:0];
    load_start = 1'b1;
    @(negedge clka);
    load_start = 1'b0;
    chk("start_err_clear", start_err, 0);
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_ready", s_ready, 0);
      @(negedge clka);
      chk("zero_done_end", done, 0);
      chk("zero_busy_end", busy, 0);
      load_finished();
      return;
    end
    acc = 0;
    while (acc < n) begin
      chk("s_ready_load", s_ready, 1);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2) == 1;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      s_valid = v;
      s_data  = DW'($urandom);
      if (cycles == dup_at) begin
        load_start = 1'b1;
        load_count = 3;
      end
      if (v && acc == abort_at) begin
        load_abort = 1'b1;
        @(negedge clka);
        load_abort = 1'b0;
        s_valid = 1'b0;
        cycles++;
        chk("abort_busy", busy, 0);
        chk("abort_ready", s_ready, 0);
        @(negedge clka);
        chk("abort_no_done", done, 0);
        return;
      end
      @(negedge clka);
      load_start = 1'b0;
      cycles++;
      if (v) begin
        mem_m[wbase() + acc] = s_data;
        known[wbase() + acc] = 1'b1;
        acc++;
      end
    end
    s_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("ready_after_last", s_ready, 0);
    chk("busy_in_done", busy, 1);
    @(negedge clka);
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    load_finished();
  endtask

  initial begin
    int cyc;
    int cnt;
    @(negedge clka);
    @(negedge clka);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_douta", douta, 0);
    rst_n = 1'b1;
    addra = 5;
    @(negedge clka);
    chk("idle_ready", s_ready, 0);
    chk("idle_busy", busy, 0);

    run_load(4, 0, -1, -1, cyc);
    chk("cycles_valid_high", cyc, 4);
    for (int a = 0; a < 4; a++) read_check(a);

    run_load(4, 1, -1, -1, cyc);
    chk("cycles_toggle", cyc, 8);
    for (int a = 0; a < 4; a++) read_check(a);

    run_load(0, 0, -1, -1, cyc);
    run_load(2047, 2, -1, -1, cyc);
    chk("cycles_clamped_min", (cyc >= DEPTH) ? 1 : 0, 1);
    for (int a = 0; a < DEPTH; a++) read_check(a);

    run_load(4, 0, 2, -1, cyc);
    for (int a = 0; a < 4; a++) read_check(a);

    run_load(4, 2, -1, 1, cyc);
    chk("start_err_set", start_err, 1);
    for (int a = 0; a < 4; a++) read_check(a);

    for (int k = 0; k < 4; k++) begin
      cnt = $urandom_range(1, 40);
      run_load(cnt, 2, -1, -1, cyc);
      for (int j = 0; j < 6; j++) read_check($urandom_range(0, cnt - 1));
      read_check(cnt - 1);
    end

    load_count = 4;
    load_start = 1'b1;
    @(negedge clka);
    load_start = 1'b1;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    @(negedge clka);
    load_start = 1'b0;
    mem_m[wbase()] = s_data;
    known[wbase()] = 1'b1;
    chk("pre_rst_start_err", start_err, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_start_err", start_err, 0);
    chk("midrst_douta", douta, 0);
    s_valid = 1'b0;
    @(negedge clka);
    rst_n = 1'b1;
    @(negedge clka);
    chk("post_rst_busy", busy, 0);
    for (int a = 0; a < 8; a++) read_check(a);

    run_load(3, 0, -1, -1, cyc);
    for (int a = 0; a < 3; a++) read_check(a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
